// File: rtl/icache_refill_axi_master_pkg.sv
// Shared definitions for the instruction-cache refill AXI read master.
// Contents: FSM state type, fixed AXI burst attributes for a 16-byte line, line width.
package icache_refill_axi_master_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAr,
        StR0,
        StR1,
        StResp
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_8B    = 3'b011;
    localparam logic [7:0] LEN_2BEAT  = 8'd1;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam int unsigned LINE_W = 128;

endpackage

// File: rtl/icache_refill_axi_master.sv
// AXI read initiator for ICache line refills. Accepts one miss address, issues a single
// 2-beat x 64-bit INCR burst for the enclosing 16-byte line, assembles the beats into a
// 128-bit line and returns it with an error flag.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr    line-fill request from the cache
//   flush                           discard the result of the refill in flight
//   resp_valid/resp_ready           line return handshake
//   resp_data/resp_err              assembled line {beat1, beat0} and error flag
//   araddr/arvalid/arready/arlen/arsize/arburst   AXI AR channel
//   rdata/rvalid/rready/rlast/rresp               AXI R channel
//
// Optional feature: define ICACHE_REFILL_TIMEOUT_EN to enable a watchdog that ends the
// refill with an error after TIMEOUT_CYCLES cycles without an AR or R handshake.
module icache_refill_axi_master
    import icache_refill_axi_master_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic [ADDR_W-1:0]   req_addr,
    output logic                req_ready,
    input  logic                flush,
    output logic                resp_valid,
    output logic [2*DATA_W-1:0] resp_data,
    output logic                resp_err,
    input  logic                resp_ready,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                rvalid,
    output logic                rready,
    input  logic                rlast,
    input  logic [1:0]          rresp
);

    localparam int unsigned LineW = 2 * DATA_W;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LineW-1:0]   data_q, data_d;
    logic               err_q, err_d;
    logic               drop_q, drop_d;

    // Low address bits are discarded by line alignment.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[3:0];

    assign arlen   = LEN_2BEAT;
    assign arsize  = SIZE_8B;
    assign arburst = BURST_INCR;

    assign araddr    = addr_q;
    assign resp_data = data_q;
    assign resp_err  = err_q;

`ifdef ICACHE_REFILL_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            on_bus;
    logic            bus_hs;
    logic            timeout;

    assign on_bus  = (state_q == StAr) || (state_q == StR0) || (state_q == StR1);
    assign bus_hs  = ((state_q == StAr) && arready) ||
                     (((state_q == StR0) || (state_q == StR1)) && rvalid);
    assign timeout = on_bus && !bus_hs && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!on_bus || bus_hs || timeout) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    int unsigned unused_timeout_cycles;
    assign unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        err_d      = err_q;
        drop_d     = drop_q;
        req_ready  = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        resp_valid = 1'b0;

        // A flush during the bus phase only marks the result for discard; the burst must
        // still drain because AXI has no abort.
        if ((state_q == StAr || state_q == StR0 || state_q == StR1) && flush) begin
            drop_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = {req_addr[ADDR_W-1:4], 4'b0000};
                    data_d  = '0;
                    err_d   = 1'b0;
                    drop_d  = 1'b0;
                    state_d = StAr;
                end
            end
            StAr: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = StR0;
                end
            end
            StR0: begin
                rready = 1'b1;
                if (rvalid) begin
                    data_d[DATA_W-1:0] = rdata;
                    if (rresp != RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    if (rlast) begin
                        // Burst ended one beat early.
                        err_d   = 1'b1;
                        state_d = drop_d ? StIdle : StResp;
                    end else begin
                        state_d = StR1;
                    end
                end
            end
            StR1: begin
                rready = 1'b1;
                if (rvalid) begin
                    data_d[LineW-1:DATA_W] = rdata;
                    if (rresp != RESP_OKAY || !rlast) begin
                        err_d = 1'b1;
                    end
                    state_d = drop_d ? StIdle : StResp;
                end
            end
            StResp: begin
                resp_valid = !drop_q;
                if (drop_q || flush || resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef ICACHE_REFILL_TIMEOUT_EN
        if (timeout) begin
            err_d   = 1'b1;
            state_d = drop_d ? StIdle : StResp;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_icache_refill_axi_master.sv
// Self-checking bench for icache_refill_axi_master: directed refills from the test plan,
// then randomized refills checked against a transaction-level expectation of the line.
module tb_icache_refill_axi_master;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         req_ready;
    logic         flush;
    logic         resp_valid;
    logic [127:0] resp_data;
    logic         resp_err;
    logic         resp_ready;
    logic [31:0]  araddr;
    logic         arvalid;
    logic         arready;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [63:0]  rdata;
    logic         rvalid;
    logic         rready;
    logic         rlast;
    logic [1:0]   rresp;

    int n_vec;
    int n_err;

    icache_refill_axi_master #(
        .ADDR_W         (32),
        .DATA_W         (64),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .resp_ready (resp_ready),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .rready     (rready),
        .rlast      (rlast),
        .rresp      (rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one R beat after 'gaps' idle cycles; rready must be up throughout.
    task automatic deliver(input logic [63:0] d, input logic [1:0] rr, input logic last,
                           input int gaps);
        for (int g = 0; g < gaps; g++) begin
            rvalid = 1'b0;
            check("rready_gap", rready, 1'b1);
            check("req_ready_busy", req_ready, 1'b0);
            step();
        end
        rvalid = 1'b1;
        rdata  = d;
        rresp  = rr;
        rlast  = last;
        check("rready_beat", rready, 1'b1);
        step();
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    // One complete refill; expected line and error follow directly from the burst contents.
    task automatic run_refill(input logic [31:0] addr, input int ar_wait,
                              input logic [63:0] b0, input logic [63:0] b1,
                              input logic [1:0] rr0, input logic [1:0] rr1,
                              input logic early, input logic last1, input int resp_wait,
                              input logic do_flush, input int gap_max);
        logic [31:0]  exp_addr;
        logic [127:0] exp_data;
        logic         exp_err;
        exp_addr = addr & 32'hFFFF_FFF0;
        exp_err  = (rr0 != 2'b00) || early || (!early && ((rr1 != 2'b00) || !last1));
        exp_data = early ? {64'd0, b0} : {b1, b0};

        check("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_addr  = addr;
        step();
        req_valid = 1'b0;
        req_addr  = $urandom;

        check("arvalid", arvalid, 1'b1);
        check("araddr", araddr, exp_addr);
        check("arlen", arlen, 8'd1);
        check("arsize", arsize, 3'b011);
        check("arburst", arburst, 2'b01);
        for (int w = 0; w < ar_wait; w++) begin
            rvalid = 1'b1;  // stray R traffic must be ignored before AR handshake
            check("rready_in_ar", rready, 1'b0);
            check("arvalid_hold", arvalid, 1'b1);
            check("araddr_hold", araddr, exp_addr);
            step();
        end
        rvalid  = 1'b0;
        arready = 1'b1;
        step();
        arready = 1'b0;
        check("arvalid_drop", arvalid, 1'b0);

        if (do_flush) begin
            flush = 1'b1;
            check("rready_flush", rready, 1'b1);
            step();
            flush = 1'b0;
        end

        deliver(b0, rr0, early, $urandom_range(gap_max, 0));
        if (!early) begin
            deliver(b1, rr1, last1, $urandom_range(gap_max, 0));
        end

        if (do_flush) begin
            check("flush_no_resp", resp_valid, 1'b0);
            check("flush_req_ready", req_ready, 1'b1);
            return;
        end

        check("resp_valid", resp_valid, 1'b1);
        check("resp_data", resp_data, exp_data);
        check("resp_err", resp_err, exp_err);
        check("rready_resp", rready, 1'b0);
        for (int w = 0; w < resp_wait; w++) begin
            step();
            check("resp_valid_hold", resp_valid, 1'b1);
            check("resp_data_hold", resp_data, exp_data);
            check("req_ready_resp", req_ready, 1'b0);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("resp_done", resp_valid, 1'b0);
        check("req_ready_after", req_ready, 1'b1);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        flush      = 1'b0;
        resp_ready = 1'b0;
        arready    = 1'b0;
        rdata      = '0;
        rvalid     = 1'b0;
        rlast      = 1'b0;
        rresp      = 2'b00;

        #12;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_data", resp_data, 128'd0);
        check("rst_araddr", araddr, 32'd0);
        rst_n = 1'b1;
        step();

        // Basic refill with AR backpressure.
        run_refill(32'h8000_0014, 2, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                   2'b00, 2'b00, 1'b0, 1'b1, 0, 1'b0, 0);
        // Sparse rvalid, response held off for 5 cycles.
        run_refill(32'h0000_1238, 0, 64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002,
                   2'b00, 2'b00, 1'b0, 1'b1, 5, 1'b0, 3);
        // SLVERR on beat 0: both beats still captured.
        run_refill(32'h0000_2000, 1, 64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0002,
                   2'b10, 2'b00, 1'b0, 1'b1, 0, 1'b0, 0);
        // rlast on beat 0: early response with error.
        run_refill(32'h0000_3004, 0, 64'h0123_4567_89AB_CDEF, 64'h0,
                   2'b00, 2'b00, 1'b1, 1'b0, 1, 1'b0, 0);
        // Missing rlast on beat 1.
        run_refill(32'h0000_400C, 0, 64'h1, 64'h2, 2'b00, 2'b00, 1'b0, 1'b0, 0, 1'b0, 1);
        // Flush in R0: burst drains, nothing returned.
        run_refill(32'h0000_5000, 0, 64'h3, 64'h4, 2'b00, 2'b00, 1'b0, 1'b1, 0, 1'b1, 1);
        // After the dropped refill a normal one still works.
        run_refill(32'h0000_6010, 0, 64'h5, 64'h6, 2'b00, 2'b00, 1'b0, 1'b1, 0, 1'b0, 0);

        // Asynchronous reset while in R1.
        req_valid = 1'b1;
        req_addr  = 32'h9000_0020;
        step();
        req_valid = 1'b0;
        arready   = 1'b1;
        step();
        arready = 1'b0;
        deliver(64'h7777_7777_7777_7777, 2'b10, 1'b0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_req_ready", req_ready, 1'b1);
        check("arst_arvalid", arvalid, 1'b0);
        check("arst_rready", rready, 1'b0);
        check("arst_resp_valid", resp_valid, 1'b0);
        check("arst_resp_err", resp_err, 1'b0);
        check("arst_resp_data", resp_data, 128'd0);
        check("arst_araddr", araddr, 32'd0);
        #10;
        rst_n = 1'b1;
        step();
        run_refill(32'hA000_0048, 1, 64'h8888_9999_AAAA_BBBB, 64'hCCCC_DDDD_EEEE_FFFF,
                   2'b00, 2'b00, 1'b0, 1'b1, 2, 1'b0, 2);

        // Randomized refills.
        for (int t = 0; t < 24; t++) begin
            logic [1:0] rr0;
            logic [1:0] rr1;
            logic       early;
            logic       last1;
            rr0   = ($urandom_range(3, 0) == 0) ? 2'($urandom) : 2'b00;
            rr1   = ($urandom_range(3, 0) == 0) ? 2'($urandom) : 2'b00;
            early = ($urandom_range(5, 0) == 0);
            last1 = ($urandom_range(5, 0) != 0);
            run_refill($urandom, $urandom_range(3, 0), {$urandom, $urandom},
                       {$urandom, $urandom}, rr0, rr1, early, last1, $urandom_range(4, 0),
                       ($urandom_range(4, 0) == 0), 2);
        end

`ifdef ICACHE_REFILL_TIMEOUT_EN
        begin
            int waited;
            req_valid = 1'b1;
            req_addr  = 32'h0000_7000;
            step();
            req_valid = 1'b0;
            arready   = 1'b1;
            step();
            arready = 1'b0;
            deliver(64'h1234_5678_9ABC_DEF0, 2'b00, 1'b0, 0);
            waited = 0;
            while (!resp_valid && waited < 50) begin
                step();
                waited++;
            end
            check("timeout_cycles", 128'(waited), 128'd8);
            check("timeout_err", resp_err, 1'b1);
            check("timeout_data", resp_data, {64'd0, 64'h1234_5678_9ABC_DEF0});
            rvalid = 1'b1;
            rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
            rlast  = 1'b1;
            check("timeout_late_rready", rready, 1'b0);
            resp_ready = 1'b1;
            step();
            resp_ready = 1'b0;
            check("timeout_late_rready2", rready, 1'b0);
            rvalid = 1'b0;
            rlast  = 1'b0;
            check("timeout_idle", req_ready, 1'b1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/icache_refill_axi_master.md
Name: icache_refill_axi_master

Overview:
- AXI read initiator for the instruction cache refill path.
- Accepts one line-fill request from the ICache and issues a single INCR burst of 2 beats x 64 bits (one 16-byte line) on the instruction-side AXI read channels.
- Assembles both beats into a 128-bit line and returns it to the cache with an error flag.
- Sits between the ICache controller and the instruction SRAM/bus slave.

Parameters:
- ADDR_W, 32, address width of request and araddr.
- DATA_W, 64, R-channel beat width; line width is 2*DATA_W.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  cache requests a line fill
- req_addr  in  ADDR_W  miss address (any byte address)
- req_ready  out  1  block idle, request accepted on valid&ready
- flush  in  1  discard result of the refill in flight
- resp_valid  out  1  line available
- resp_data  out  2*DATA_W  assembled line; beat0 in [63:0], beat1 in [127:64]
- resp_err  out  1  bus error or protocol violation during this refill
- resp_ready  in  1  cache consumes the line
- araddr  out  ADDR_W  {req_addr[31:4],4'b0}
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- arlen  out  8  constant 8'd1 (2 beats)
- arsize  out  3  constant 3'b011 (8 bytes)
- arburst  out  2  constant 2'b01 (INCR)
- rdata  in  DATA_W  read beat
- rvalid  in  1  R valid
- rready  out  1  R ready
- rlast  in  1  last beat
- rresp  in  2  beat response; nonzero = error

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; req_ready = 1; arvalid = 0; rready = 0; resp_valid = 0; resp_err = 0.
  - resp_data and araddr = 0; sticky error and drop flags cleared.
- FSM states IDLE, AR, R0, R1, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch the aligned address, clear the error and drop flags, go to AR.
- AR:
  - arvalid = 1; araddr held stable until handshake.
  - On arready, go to R0; arvalid drops the next cycle.
  - rvalid while in AR is ignored (rready = 0).
- R0:
  - rready = 1.
  - On rvalid: store rdata into [63:0]; if rresp != 0, set err.
  - If rlast = 1 on beat 0 (early last), set err and go to RESP; otherwise go to R1.
- R1:
  - rready = 1.
  - On rvalid: store rdata into [127:64]; if rresp != 0, set err; if rlast = 0, set err.
  - Go to RESP either way.
- RESP:
  - resp_valid = 1, held with resp_data/resp_err stable until resp_ready.
  - On resp_ready, go to IDLE.
  - If the drop flag is set, resp_valid stays 0 and the FSM goes directly to IDLE.
- Flush:
  - A flush in AR/R0/R1 sets the drop flag; the burst still completes on the bus (AXI cannot abort).
  - A flush in RESP deasserts resp_valid and returns to IDLE the next cycle.
  - A flush in IDLE has no effect.
- Latency, zero-wait slave: req accept -> arvalid next cycle -> 2 beats -> resp_valid. Minimum 4 cycles from req accept to resp_valid.
- Only one outstanding transaction; req_ready = 0 in all non-IDLE states.
- Back-to-back: the same cycle resp_ready is accepted, the FSM enters IDLE and a new request is accepted the next cycle.

Optional Feature:
- Macro: ICACHE_REFILL_TIMEOUT_EN.
- Defined: a counter increments each cycle in AR/R0/R1 while no handshake occurs and resets on each handshake. On reaching TIMEOUT_CYCLES, the FSM sets err and enters RESP, returning the partial line (missing beats are 0). rready stays deasserted afterwards; a late beat is never consumed.
- Undefined: no counter; the FSM waits indefinitely.

Decomposition:
- Shared package:
  - State enum.
  - AXI constants: BURST_INCR = 2'b01, SIZE_8B = 3'b011, LEN_2BEAT = 8'd1, RESP_OKAY = 2'b00.
  - Line width constant.
- No sub-module needed. The timeout counter stays inline under the macro.

Test Plan:
- req_addr 0x8000_0014, slave arready after 2 cycles, beats 0x1111_2222_3333_4444 then 0x5555_6666_7777_8888 with rlast on beat 1 -> araddr 0x8000_0010, arlen 1, arsize 3, arburst 1; resp_data {beat1,beat0}; resp_err 0.
- rvalid toggled randomly, resp_ready held low 5 cycles -> data correct; resp_valid/resp_data stable all 5 cycles; req_ready 0 until the resp handshake.
- Beat 0 rresp = 2'b10 -> resp_err 1, both beats still captured. Separately, rlast on beat 0 -> resp_err 1 and early RESP.
- flush asserted in R0 -> burst completes (2 rready handshakes), no resp_valid, req_ready 1 one cycle after beat 1.
- rst_n pulled low in R1 -> all outputs at reset values immediately (asynchronous); after release, req_ready 1 and a new refill completes correctly.
- ICACHE_REFILL_TIMEOUT_EN, TIMEOUT_CYCLES 8, slave withholds beat 1 -> resp_valid with resp_err 1 and resp_data[127:64] = 0 after 8 idle cycles.
